// File: rtl/pipelined_adder_pkg.sv
// Shared constants and stage payload for pipelined_adder.
// Optional saturation is enabled with PIPELINED_ADDER_SATURATE_EN.
package adder_pkg;

  localparam int MAX_WIDTH  = 64;
  localparam int MAX_STAGES = 4;

  typedef struct packed {
    logic                 valid;
    logic [MAX_WIDTH-1:0] sum;
    logic                 carry;
    logic [MAX_WIDTH-1:0] a;
    logic [MAX_WIDTH-1:0] b;
    logic                 sub;
    logic                 sat;
  } stage_t;

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// Saturation via io_sat only matters with PIPELINED_ADDER_SATURATE_EN.
interface pipelined_adder_if #(
  parameter int WIDTH = 16
);

  logic             io_in_valid;
  logic             io_in_ready;
  logic [WIDTH-1:0] io_a;
  logic [WIDTH-1:0] io_b;
  logic             io_sub;
  logic             io_sat;
  logic             io_out_valid;
  logic             io_out_ready;
  logic [WIDTH-1:0] io_c;
  logic             io_carry;
  logic             io_ovf;

  modport master (
    output io_in_valid,
    output io_a,
    output io_b,
    output io_sub,
    output io_sat,
    output io_out_ready,
    input  io_in_ready,
    input  io_out_valid,
    input  io_c,
    input  io_carry,
    input  io_ovf
  );

  modport slave (
    input  io_in_valid,
    input  io_a,
    input  io_b,
    input  io_sub,
    input  io_sat,
    input  io_out_ready,
    output io_in_ready,
    output io_out_valid,
    output io_c,
    output io_carry,
    output io_ovf
  );

endinterface

// File: rtl/pipelined_adder_slice.sv
// One registered chunk of the carry-pipelined adder.
// Used by pipelined_adder (PIPELINED_ADDER_SATURATE_EN independent).
module adder_slice
  import adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2,
  parameter int K      = 0
) (
  input  logic   clk,
  input  logic   reset_n,
  input  stage_t in_p,
  input  logic   ready_next,
  output logic   ready,
  output stage_t out_p
);

  localparam int CW = WIDTH / STAGES;
  localparam int LO = K * CW;

  logic [CW:0] s;
  stage_t      nxt;

  assign s = {1'b0, in_p.a[LO +: CW]}
           + {1'b0, in_p.b[LO +: CW]}
           + (CW+1)'(in_p.carry);

  // A stage may load when it is empty or its content moves on.
  assign ready = !out_p.valid || ready_next;

  always_comb begin
    nxt               = in_p;
    nxt.sum[LO +: CW] = s[CW-1:0];
    nxt.carry         = s[CW];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_p <= '0;
    end else if (ready) begin
      if (in_p.valid) begin
        out_p <= nxt;
      end else begin
        out_p.valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pipelined_adder.sv
// Valid/ready add/subtract pipeline, one chunk per stage.
// Define PIPELINED_ADDER_SATURATE_EN to enable io_sat clamping.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_a,
  input  logic [WIDTH-1:0] io_b,
  input  logic             io_sub,
  input  logic             io_sat,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_c,
  output logic             io_carry,
  output logic             io_ovf
);

  stage_t head;
  stage_t st  [1:STAGES];
  logic   rdy [1:STAGES+1];

  always_comb begin
    head                = '0;
    head.valid          = io_in_valid;
    head.a[WIDTH-1:0]   = io_a;
    head.b[WIDTH-1:0]   = io_sub ? ~io_b : io_b;
    head.carry          = io_sub;
    head.sub            = io_sub;
`ifdef PIPELINED_ADDER_SATURATE_EN
    head.sat            = io_sat;
`else
    head.sat            = 1'b0;
`endif
  end

  assign rdy[STAGES+1] = io_out_ready;
  assign io_in_ready   = rdy[1];

  for (genvar k = 1; k <= STAGES; k++) begin : g_stage
    stage_t src;
    if (k == 1) begin : g_first
      assign src = head;
    end else begin : g_next
      assign src = st[k-1];
    end
    adder_slice #(
      .WIDTH (WIDTH),
      .STAGES(STAGES),
      .K     (k - 1)
    ) u_slice (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_p      (src),
      .ready_next(rdy[k+1]),
      .ready     (rdy[k]),
      .out_p     (st[k])
    );
  end

  stage_t           last;
  logic [WIDTH-1:0] sum_w;
  logic             sa;
  logic             sb;
  logic             ovf;

  assign last  = st[STAGES];
  assign sum_w = last.sum[WIDTH-1:0];
  assign sa    = last.a[WIDTH-1];
  assign sb    = last.b[WIDTH-1];
  assign ovf   = (sa == sb) && (sum_w[WIDTH-1] != sa);

  assign io_out_valid = last.valid;
  assign io_carry     = last.carry;
  assign io_ovf       = ovf;

`ifdef PIPELINED_ADDER_SATURATE_EN
  localparam logic [WIDTH-1:0] SMAX =
    {1'b0, {(WIDTH-1){1'b1}}};

  // Both operands negative means the overflow went below min.
  assign io_c = (last.sat && ovf)
              ? (sa ? ~SMAX : SMAX)
              : sum_w;
`else
  assign io_c = sum_w;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Randomised and directed bench for pipelined_adder (WIDTH=16, STAGES=2).
// Sat expectations follow PIPELINED_ADDER_SATURATE_EN when defined.
module tb_pipelined_adder;

  localparam int W      = 16;
  localparam int STAGES = 2;

  typedef struct {
    logic [W-1:0] c;
    logic         carry;
    logic         ovf;
    int           acc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;

  pipelined_adder_if #(.WIDTH(W)) bus ();

  pipelined_adder #(
    .WIDTH (W),
    .STAGES(STAGES)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .io_in_valid (bus.io_in_valid),
    .io_in_ready (bus.io_in_ready),
    .io_a        (bus.io_a),
    .io_b        (bus.io_b),
    .io_sub      (bus.io_sub),
    .io_sat      (bus.io_sat),
    .io_out_valid(bus.io_out_valid),
    .io_out_ready(bus.io_out_ready),
    .io_c        (bus.io_c),
    .io_carry    (bus.io_carry),
    .io_ovf      (bus.io_ovf)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   stall_left = 0;
  bit   rnd_bp = 0;
  exp_t q[$];

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic exp_t model(logic [W-1:0] a,
                                 logic [W-1:0] b,
                                 logic sub, logic sat);
    exp_t e;
    int   sa;
    int   sb;
    int   r;
    logic [W:0] u;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r  = sub ? sa - sb : sa + sb;
    u  = {1'b0, a} + {1'b0, b};
    e.c     = sub ? a - b : a + b;
    e.carry = sub ? (a >= b) : u[W];
    e.ovf   = (r > 32767) || (r < -32768);
    e.acc   = 0;
`ifdef PIPELINED_ADDER_SATURATE_EN
    if (sat && e.ovf) e.c = (r > 0) ? 16'h7fff : 16'h8000;
`else
    if (sat) e.ovf = e.ovf;
`endif
    return e;
  endfunction

  task automatic cycle(output bit acc);
    bit   ov;
    bit   outx;
    exp_t e;
    if (stall_left > 0) begin
      bus.io_out_ready = 1'b0;
      stall_left--;
    end else begin
      bus.io_out_ready =
        rnd_bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    #1;
    ov = (q.size() > 0) && (cyc - q[0].acc >= STAGES);
    chk("out_valid", 64'(bus.io_out_valid), 64'(ov));
    chk("in_ready", 64'(bus.io_in_ready),
        64'(!(q.size() == STAGES && !bus.io_out_ready)));
    if (ov) begin
      chk("c", 64'(bus.io_c), 64'(q[0].c));
      chk("carry", 64'(bus.io_carry), 64'(q[0].carry));
      chk("ovf", 64'(bus.io_ovf), 64'(q[0].ovf));
    end
    acc  = bus.io_in_valid && bus.io_in_ready;
    outx = ov && bus.io_out_ready;
    @(posedge clk);
    if (outx) void'(q.pop_front());
    if (acc) begin
      e = model(bus.io_a, bus.io_b,
                bus.io_sub, bus.io_sat);
      e.acc = cyc;
      q.push_back(e);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic send(logic [W-1:0] a, logic [W-1:0] b,
                      logic sub, logic sat);
    bit acc;
    int n;
    n = 0;
    bus.io_in_valid = 1'b1;
    bus.io_a   = a;
    bus.io_b   = b;
    bus.io_sub = sub;
    bus.io_sat = sat;
    do begin
      cycle(acc);
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("accept_timeout", 64'(acc), 64'(1));
    bus.io_in_valid = 1'b0;
  endtask

  task automatic idle();
    bit acc;
    bus.io_in_valid = 1'b0;
    cycle(acc);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 60) begin
      idle();
      n++;
    end
    if (q.size() > 0)
      chk("drain_timeout", 64'(q.size()), 64'(0));
    idle();
  endtask

  task automatic chk_reset_state();
    chk("rst_out_valid", 64'(bus.io_out_valid), 64'(0));
    chk("rst_c", 64'(bus.io_c), 64'(0));
    chk("rst_carry", 64'(bus.io_carry), 64'(0));
    chk("rst_ovf", 64'(bus.io_ovf), 64'(0));
    chk("rst_in_ready", 64'(bus.io_in_ready), 64'(1));
  endtask

  initial begin
    reset_n          = 1'b0;
    bus.io_in_valid  = 1'b0;
    bus.io_a         = '0;
    bus.io_b         = '0;
    bus.io_sub       = 1'b0;
    bus.io_sat       = 1'b0;
    bus.io_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_state();
    reset_n = 1'b1;
    @(negedge clk);

    send(16'd3, 16'd7, 1'b0, 1'b0);
    drain();
    send(16'hffff, 16'h0001, 1'b0, 1'b0);
    drain();
    send(16'h00ff, 16'h0001, 1'b0, 1'b0);
    drain();
    send(16'd5, 16'd7, 1'b1, 1'b0);
    drain();
    send(16'd7, 16'd5, 1'b1, 1'b0);
    drain();
    send(16'h7fff, 16'h0001, 1'b0, 1'b0);
    drain();
    send(16'h7fff, 16'h0001, 1'b0, 1'b1);
    drain();
    send(16'h8000, 16'h0001, 1'b1, 1'b1);
    drain();
    send(16'h0000, 16'h8000, 1'b1, 1'b0);
    drain();

    // Four beats against a four-cycle output stall.
    stall_left = 4;
    send(16'h1111, 16'h0101, 1'b0, 1'b0);
    send(16'h2222, 16'h0202, 1'b1, 1'b0);
    send(16'h7000, 16'h7000, 1'b0, 1'b1);
    send(16'h9000, 16'h7000, 1'b1, 1'b1);
    drain();

    // Reset with two beats in flight.
    send(16'h1234, 16'h1111, 1'b0, 1'b0);
    send(16'h4321, 16'h0101, 1'b1, 1'b0);
    reset_n = 1'b0;
    #1;
    chk_reset_state();
    q.delete();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    idle();
    send(16'h0aaa, 16'h0555, 1'b0, 1'b0);
    drain();

    rnd_bp = 1;
    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 2)) idle();
      send(16'($urandom), 16'($urandom),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
    end
    rnd_bp = 0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
